// File: rtl/flag_branch_unit_pkg.sv
// Shared constants for the ALU-to-branch flag path: widths, flag bit
// positions, opcode and condition encodings, and the flag-setting predicate.
package flag_branch_unit_pkg;

  localparam int opsize   = 4;
  localparam int numflags = 4;
  localparam int pcwidth  = 8;

  // Flag vector bit order is {C V Z N}
  localparam int flag_c = 3;
  localparam int flag_v = 2;
  localparam int flag_z = 1;
  localparam int flag_n = 0;

  typedef enum logic [opsize-1:0] {
    op_add = 4'h0,
    op_sub = 4'h1,
    op_and = 4'h2,
    op_or  = 4'h3,
    op_xor = 4'h4,
    op_not = 4'h5,
    op_ls  = 4'h6,
    op_rs  = 4'h7,
    op_cmp = 4'h8,
    op_mov = 4'h9,
    op_nop = 4'hf
  } opcode_e;

  // ARM-style condition codes
  typedef enum logic [3:0] {
    cond_eq = 4'h0,
    cond_ne = 4'h1,
    cond_cs = 4'h2,
    cond_cc = 4'h3,
    cond_mi = 4'h4,
    cond_pl = 4'h5,
    cond_vs = 4'h6,
    cond_vc = 4'h7,
    cond_hi = 4'h8,
    cond_ls = 4'h9,
    cond_ge = 4'ha,
    cond_lt = 4'hb,
    cond_gt = 4'hc,
    cond_le = 4'hd,
    cond_al = 4'he,
    cond_nv = 4'hf
  } cond_e;

  // True for opcodes whose completion overwrites the status register
  function automatic logic flag_setting(input logic [opsize-1:0] op);
    case (op)
      op_add, op_sub, op_cmp, op_and, op_or, op_ls, op_rs: flag_setting = 1'b1;
      default:                                             flag_setting = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/flag_branch_unit_if.sv
// ALU result/flag feed, branch request and branch result channels.
// master = ALU/fetch side that drives requests, slave = flag_branch_unit.
interface flag_branch_unit_if;
  import flag_branch_unit_pkg::*;

  logic                alu_valid;
  logic [opsize-1:0]   alu_opcode;
  logic [numflags-1:0] alu_flags;

  logic                br_valid;
  logic                br_ready;
  logic [3:0]          br_cond;
  logic [pcwidth-1:0]  br_pc;
  logic [pcwidth-1:0]  br_target;

  logic                res_valid;
  logic                res_ready;
  logic                taken;
  logic [pcwidth-1:0]  next_pc;
  logic [numflags-1:0] status;

  modport master (
    output alu_valid, alu_opcode, alu_flags,
    output br_valid, br_cond, br_pc, br_target,
    output res_ready,
    input  br_ready, res_valid, taken, next_pc, status
  );

  modport slave (
    input  alu_valid, alu_opcode, alu_flags,
    input  br_valid, br_cond, br_pc, br_target,
    input  res_ready,
    output br_ready, res_valid, taken, next_pc, status
  );

endinterface

// File: rtl/flag_branch_unit_cond_eval.sv
// Combinational condition evaluator: {C V Z N} flags + 4-bit condition code
// -> taken. Kept standalone so predicated execute can reuse it.
module cond_eval
  import flag_branch_unit_pkg::*;
(
  input  logic [numflags-1:0] flags,
  input  logic [3:0]          cond,
  output logic                taken
);

  logic c, v, z, n;

  assign c = flags[flag_c];
  assign v = flags[flag_v];
  assign z = flags[flag_z];
  assign n = flags[flag_n];

  // Decode the condition code against the flag bits
  always_comb begin
    // NOTE: default first so every path assigns taken and no latch is inferred.
    taken = 1'b0;
    case (cond)
      cond_eq: taken = z;
      cond_ne: taken = !z;
      cond_cs: taken = c;
      cond_cc: taken = !c;
      cond_mi: taken = n;
      cond_pl: taken = !n;
      cond_vs: taken = v;
      cond_vc: taken = !v;
      cond_hi: taken = c & !z;
      cond_ls: taken = !c | z;
      cond_ge: taken = (n == v);
      cond_lt: taken = (n != v);
      cond_gt: taken = !z & (n == v);
      cond_le: taken = z | (n != v);
      cond_al: taken = 1'b1;
      cond_nv: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Branch resolution unit: latches ALU flags into a status register and
// resolves conditional branches with one cycle of latency. Flags arriving in
// the same cycle as a branch are forwarded around the status register.
module flag_branch_unit
  import flag_branch_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  flag_branch_unit_if.slave bus
);

  logic [numflags-1:0] status_q;
  logic [numflags-1:0] eval_flags;
  logic                res_valid_q;
  logic                taken_q;
  logic [pcwidth-1:0]  next_pc_q;
  logic [pcwidth-1:0]  pc_inc;
  logic [pcwidth-1:0]  resolved_pc;
  logic                flag_update;
  logic                br_ready;
  logic                accept;
  logic                cond_taken;

  assign flag_update = bus.alu_valid & flag_setting(bus.alu_opcode);

  // Same-cycle flag update wins over the stale status value
  assign eval_flags = flag_update ? bus.alu_flags : status_q;

  // Output register frees up either when empty or when drained this cycle
  assign br_ready = !res_valid_q | bus.res_ready;
  assign accept   = bus.br_valid & br_ready;

  cond_eval u_cond_eval (
    .flags (eval_flags),
    .cond  (bus.br_cond),
    .taken (cond_taken)
  );

  // Fall-through wraps modulo 2^pcwidth
  assign pc_inc      = bus.br_pc + pcwidth'(1);
  assign resolved_pc = cond_taken ? bus.br_target : pc_inc;

  // Status register: captures all four flags from flag-setting ops
  always_ff @(posedge clk) begin
    // NOTE: every register here is reset synchronously; state uses <= so all
    // flops update from the same pre-edge values.
    if (reset) begin
      status_q <= '0;
    end else if (flag_update) begin
      status_q <= bus.alu_flags;
    end
  end

  // Result register: load on accept, hold until consumed, drop on drain
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      next_pc_q   <= '0;
    end else if (accept) begin
      res_valid_q <= 1'b1;
      taken_q     <= cond_taken;
      next_pc_q   <= resolved_pc;
    end else if (bus.res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign bus.br_ready  = br_ready;
  assign bus.res_valid = res_valid_q;
  assign bus.taken     = taken_q;
  assign bus.next_pc   = next_pc_q;
  assign bus.status    = status_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Self-checking bench for flag_branch_unit. A reference model tracks status,
// result-valid and the held result; expected branch results are queued when a
// request is accepted and popped when the DUT registers its result.
module tb_flag_branch_unit;
  import flag_branch_unit_pkg::*;

  logic clk;
  logic reset;

  flag_branch_unit_if bif ();

  flag_branch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [3:0] m_status;
  logic       m_valid;
  logic       m_taken;
  logic [7:0] m_next_pc;
  logic [8:0] sb[$];

  function automatic logic is_flag_op(input logic [3:0] op);
    return (op == op_add) || (op == op_sub) || (op == op_cmp) ||
           (op == op_and) || (op == op_or)  || (op == op_ls)  || (op == op_rs);
  endfunction

  // Pairwise model: even code tests a base predicate, odd code inverts it
  function automatic logic cond_model(input logic [3:0] cond, input logic [3:0] f);
    logic c, v, z, n, base;
    c = f[3]; v = f[2]; z = f[1]; n = f[0];
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return cond[0] ? !base : base;
  endfunction

  // One clock: check ready, predict, clock, then compare all outputs
  task automatic cycle();
    logic       acc;
    logic [3:0] ef;
    logic       t;
    logic [7:0] np;
    logic [8:0] e;
    #1;
    if (!reset) begin
      checks++;
      if (bif.br_ready !== (!m_valid || bif.res_ready)) begin
        errors++;
        $display("FAIL br_ready: got %b want %b", bif.br_ready, (!m_valid || bif.res_ready));
      end
    end
    acc = !reset && bif.br_valid && (!m_valid || bif.res_ready);
    if (acc) begin
      ef = (bif.alu_valid && is_flag_op(bif.alu_opcode)) ? bif.alu_flags : m_status;
      t  = cond_model(bif.br_cond, ef);
      np = t ? bif.br_target : bif.br_pc + 8'd1;
      sb.push_back({t, np});
    end
    @(posedge clk);
    if (reset) begin
      m_status  = '0;
      m_valid   = 1'b0;
      m_taken   = 1'b0;
      m_next_pc = '0;
      sb.delete();
    end else begin
      if (bif.alu_valid && is_flag_op(bif.alu_opcode)) m_status = bif.alu_flags;
      if (acc) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: empty at accept");
        end else begin
          e = sb.pop_front();
          m_taken   = e[8];
          m_next_pc = e[7:0];
        end
        m_valid = 1'b1;
      end else if (bif.res_ready) begin
        m_valid = 1'b0;
      end
    end
    #1;
    checks++;
    if (bif.res_valid !== m_valid || bif.status !== m_status ||
        bif.taken !== m_taken || bif.next_pc !== m_next_pc) begin
      errors++;
      $display("FAIL outputs: got valid=%b status=%h taken=%b next_pc=%h want valid=%b status=%h taken=%b next_pc=%h",
               bif.res_valid, bif.status, bif.taken, bif.next_pc,
               m_valid, m_status, m_taken, m_next_pc);
    end
  endtask

  task automatic idle_inputs();
    bif.alu_valid  = 1'b0;
    bif.alu_opcode = op_nop;
    bif.alu_flags  = '0;
    bif.br_valid   = 1'b0;
    bif.br_cond    = cond_nv;
    bif.br_pc      = '0;
    bif.br_target  = '0;
    bif.res_ready  = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    bif.alu_valid  = 1'b1;
    bif.alu_opcode = op_add;
    bif.alu_flags  = 4'hf;
    cycle();
    cycle();
    checks++;
    if (bif.status !== 4'h0 || bif.res_valid !== 1'b0 || bif.taken !== 1'b0 || bif.next_pc !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: status=%h res_valid=%b taken=%b next_pc=%h want 0 0 0 00",
               bif.status, bif.res_valid, bif.taken, bif.next_pc);
    end
    reset = 1'b0;
    bif.alu_valid = 1'b0;
    #1;
    checks++;
    if (bif.br_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: br_ready=%b want 1", bif.br_ready);
    end
  endtask

  task automatic test_flag_latch();
    bif.alu_valid  = 1'b1;
    bif.alu_opcode = op_cmp;
    bif.alu_flags  = 4'b0010;
    cycle();
    bif.alu_valid  = 1'b0;
    bif.alu_opcode = op_and;
    bif.alu_flags  = 4'b1101;
    cycle();
    bif.alu_valid  = 1'b1;
    bif.alu_opcode = op_xor;
    cycle();
    checks++;
    if (bif.status !== 4'b0010) begin
      errors++;
      $display("FAIL flag_latch: status=%b want 0010", bif.status);
    end
    bif.alu_valid = 1'b0;
    bif.br_valid  = 1'b1;
    bif.br_cond   = cond_eq;
    bif.br_pc     = 8'h10;
    bif.br_target = 8'h40;
    cycle();
    checks++;
    if (bif.res_valid !== 1'b1 || bif.taken !== 1'b1 || bif.next_pc !== 8'h40) begin
      errors++;
      $display("FAIL eq_branch: valid=%b taken=%b next_pc=%h want 1 1 40",
               bif.res_valid, bif.taken, bif.next_pc);
    end
    bif.br_valid = 1'b0;
    cycle();
  endtask

  task automatic test_forwarding();
    bif.alu_valid  = 1'b1;
    bif.alu_opcode = op_add;
    bif.alu_flags  = 4'b0000;
    cycle();
    bif.alu_opcode = op_sub;
    bif.alu_flags  = 4'b0001;
    bif.br_valid   = 1'b1;
    bif.br_cond    = cond_lt;
    bif.br_pc      = 8'h20;
    bif.br_target  = 8'h05;
    cycle();
    checks++;
    if (bif.taken !== 1'b1 || bif.next_pc !== 8'h05 || bif.status !== 4'b0001) begin
      errors++;
      $display("FAIL forwarding: taken=%b next_pc=%h status=%b want 1 05 0001",
               bif.taken, bif.next_pc, bif.status);
    end
    bif.alu_valid = 1'b0;
    bif.br_valid  = 1'b0;
    cycle();
  endtask

  task automatic test_backpressure();
    bif.res_ready = 1'b0;
    bif.br_valid  = 1'b1;
    bif.br_cond   = cond_al;
    bif.br_pc     = 8'h30;
    bif.br_target = 8'h33;
    cycle();
    // New request held off; flags change underneath the held result
    bif.br_cond    = cond_eq;
    bif.br_pc      = 8'h50;
    bif.br_target  = 8'h77;
    bif.alu_valid  = 1'b1;
    bif.alu_opcode = op_or;
    bif.alu_flags  = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      cycle();
      bif.alu_valid = 1'b0;
      checks++;
      if (bif.br_ready !== 1'b0 || bif.taken !== 1'b1 || bif.next_pc !== 8'h33) begin
        errors++;
        $display("FAIL backpressure_hold: br_ready=%b taken=%b next_pc=%h want 0 1 33",
                 bif.br_ready, bif.taken, bif.next_pc);
      end
    end
    bif.res_ready = 1'b1;
    cycle();
    checks++;
    if (bif.res_valid !== 1'b1 || bif.taken !== 1'b1 || bif.next_pc !== 8'h77) begin
      errors++;
      $display("FAIL back_to_back: valid=%b taken=%b next_pc=%h want 1 1 77",
               bif.res_valid, bif.taken, bif.next_pc);
    end
    bif.br_valid = 1'b0;
    cycle();
  endtask

  task automatic test_wrap_never();
    bif.res_ready = 1'b1;
    bif.br_valid  = 1'b1;
    bif.br_cond   = cond_nv;
    bif.br_pc     = 8'hff;
    bif.br_target = 8'h44;
    cycle();
    checks++;
    if (bif.taken !== 1'b0 || bif.next_pc !== 8'h00) begin
      errors++;
      $display("FAIL nv_wrap: taken=%b next_pc=%h want 0 00", bif.taken, bif.next_pc);
    end
    bif.br_cond   = cond_al;
    bif.br_pc     = 8'h7f;
    bif.br_target = 8'h01;
    cycle();
    checks++;
    if (bif.taken !== 1'b1 || bif.next_pc !== 8'h01) begin
      errors++;
      $display("FAIL al_branch: taken=%b next_pc=%h want 1 01", bif.taken, bif.next_pc);
    end
    bif.br_valid = 1'b0;
    cycle();
  endtask

  task automatic test_sweep();
    for (int f = 0; f < 16; f++) begin
      bif.br_valid   = 1'b0;
      bif.alu_valid  = 1'b1;
      bif.alu_opcode = op_sub;
      bif.alu_flags  = 4'(f);
      cycle();
      bif.alu_valid = 1'b0;
      bif.res_ready = 1'b1;
      for (int c = 0; c < 16; c++) begin
        bif.br_valid  = 1'b1;
        bif.br_cond   = 4'(c);
        bif.br_pc     = 8'($urandom_range(0, 255));
        bif.br_target = 8'($urandom_range(0, 255));
        cycle();
      end
    end
    bif.br_valid = 1'b0;
    cycle();
  endtask

  task automatic test_reset_mid_hold();
    bif.res_ready = 1'b0;
    bif.br_valid  = 1'b1;
    bif.br_cond   = cond_al;
    bif.br_pc     = 8'h03;
    bif.br_target = 8'h09;
    cycle();
    bif.br_valid = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    checks++;
    if (bif.res_valid !== 1'b0 || bif.status !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid_hold: res_valid=%b status=%h want 0 0", bif.res_valid, bif.status);
    end
    reset = 1'b0;
    bif.res_ready = 1'b1;
    cycle();
    checks++;
    if (bif.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_pulse: res_valid=%b want 0", bif.res_valid);
    end
  endtask

  initial begin
    m_status  = '0;
    m_valid   = 1'b0;
    m_taken   = 1'b0;
    m_next_pc = '0;
    reset     = 1'b1;
    idle_inputs();
    test_reset();
    test_flag_latch();
    test_forwarding();
    test_backpressure();
    test_wrap_never();
    test_sweep();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
